// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receiver and transmitter: the receiver
//   FSM state type, the default bit period (50 MHz clock / 115200 baud) and
//   the payload width.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int DATA_BITS_DEFAULT    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input. Both flops reset
//   to 1 so an idle-high serial line looks idle straight out of reset.
//
//   Ports:
//     clk   - destination clock
//     reset - asynchronous, active-high reset
//     d     - asynchronous input
//     q     - synchronized output (two-cycle latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. The line is synchronized, a start bit is confirmed at
//   its middle, then data and stop bits are sampled once per bit period,
//   LSB first. A good stop bit publishes the byte; a low stop bit flags a
//   framing error and the receiver waits for the line to go high again.
//
//   Parameters:
//     CLKS_PER_BIT - clock cycles per bit period (8..65535)
//     DATA_BITS    - payload bits per frame (only 8 supported)
//
//   Ports:
//     clk         - clock, all state changes on its rising edge
//     reset       - asynchronous, active-high reset
//     rx          - asynchronous serial line, idle high
//     enable      - permits detection of a new start bit
//     data_bus    - last correctly framed byte
//     rx_done     - one-cycle pulse when data_bus is updated
//     frame_error - one-cycle pulse when the stop bit samples low
//     busy        - high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       enable,
    output logic [7:0] data_bus,
    output logic       rx_done,
    output logic       frame_error,
    output logic       busy
);

    localparam int BAUD_W = 16;
    localparam int BIT_W  = $clog2(DATA_BITS);

    // Terminal counts: the sample point is the last cycle of the count, and
    // the counter reloads to 0 there, so it never wraps inside a bit.
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    uart_state_t          state_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 sample;
    logic                 stop_ok;
    logic                 stop_bad;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State register.
    // NOTE: sequential state is always written with <= so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (enable && !rx_s) state_next = START;
            START:     if (sample) state_next = rx_s ? IDLE : DATA;
            DATA:      if (sample && (bit_cnt == LAST_BIT)) state_next = STOP;
            STOP:      if (sample) state_next = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output / strobe logic decoded from the current state.
    always_comb begin
        busy   = 1'b1;
        sample = 1'b0;
        case (state)
            IDLE:       busy   = 1'b0;
            START:      sample = (baud_cnt == HALF_LAST);
            DATA, STOP: sample = (baud_cnt == FULL_LAST);
            default:    ;
        endcase
        stop_ok  = (state == STOP) && sample && rx_s;
        stop_bad = (state == STOP) && sample && !rx_s;
    end

    // Datapath: baud/bit counters, shift register and registered outputs.
    // rx_done is registered alongside data_bus so both change on the same
    // edge, and stop_ok/stop_bad are exclusive so the pulses never overlap.
    // NOTE: the shift register is reset with everything else; it is small
    // and a defined value keeps data_bus free of X if a frame is ever cut.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_bus    <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_done     <= stop_ok;
            frame_error <= stop_bad;
            if (stop_ok) begin
                data_bus <= shift_reg;
            end

            case (state)
                START, DATA, STOP: baud_cnt <= sample ? '0 : baud_cnt + 1'b1;
                default:           baud_cnt <= '0;
            endcase

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if ((state == DATA) && sample) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end
        end
    end

endmodule : uart_rx
